conv_da_mac: RTL and testbench



---
 rtl/conv_da_mac.sv | 119 +++++++++++
 tb/tb_conv_da_mac.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_da_mac.sv
// Distributed-arithmetic dot-product engine: one input bit plane per clock,
// MSB first, with a runtime-programmable partial-sum LUT.
module conv_da_mac #(
   parameter int TAPS  = 4,
   parameter int DW    = 8,
   parameter int LW    = 10,
   parameter int ACC_W = LW + DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [TAPS-1:0]      cfg_addr,
   input  logic [LW-1:0]        cfg_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [TAPS*DW-1:0]   in_data,
   input  logic                 in_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_data
);

   localparam int DEPTH = 1 << TAPS;
   localparam int BW    = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [LW-1:0]        lut_q [DEPTH];
   logic [TAPS*DW-1:0]   vec_q, vec_d;
   logic                 sgn_q, sgn_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [BW-1:0]        b_q, b_d;
   logic [ACC_W-1:0]     out_q, out_d;
   logic                 ov_q, ov_d;
   logic [TAPS-1:0]      addr;
   logic [ACC_W-1:0]     lut_ext;
   logic                 msb_plane;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         sgn_q   <= 1'b0;
         acc_q   <= '0;
         b_q     <= '0;
         out_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         sgn_q   <= sgn_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
      end
   end

   // Writes land at the edge, so a same-cycle lookup still sees the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
      end else if (cfg_we) begin
         lut_q[cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (b_q == '0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr = '0;
      for (int i = 0; i < TAPS; i++) addr[i] = vec_q[i*DW + int'(b_q)];
      lut_ext   = ACC_W'(lut_q[addr]);
      msb_plane = (b_q == BW'(DW - 1));
   end

   always_comb begin
      vec_d = vec_q;
      sgn_d = sgn_q;
      acc_d = acc_q;
      b_d   = b_q;
      out_d = out_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               vec_d = in_data;
               sgn_d = in_signed;
               acc_d = '0;
               b_d   = BW'(DW - 1);
            end
         end
         RUN: begin
            // The sign plane carries negative weight in two's complement.
            if (msb_plane && sgn_q) acc_d = (acc_q << 1) - lut_ext;
            else                    acc_d = (acc_q << 1) + lut_ext;
            if (b_q != '0) b_d = b_q - BW'(1);
            else           out_d = acc_d;
         end
         default: ;
      endcase
      ov_d = (state_d == DONE);
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = ov_q;
      out_data  = out_q;
   end

endmodule

// File: tb/tb_conv_da_mac.sv
// Directed self-checking bench for conv_da_mac: default widths plus a
// one-plane instance used as a threshold detector.
module tb_conv_da_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [9:0]  cfg_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] out_data;

   logic        cfg2_we;
   logic [3:0]  cfg2_addr;
   logic [9:0]  cfg2_data;
   logic        in2_valid;
   logic        in2_ready;
   logic [3:0]  in2_data;
   logic        out2_valid;
   logic [10:0] out2_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv_da_mac dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   conv_da_mac #(.TAPS(4), .DW(1), .LW(10)) dut2 (
      .clk(clk), .rst(rst),
      .cfg_we(cfg2_we), .cfg_addr(cfg2_addr), .cfg_data(cfg2_data),
      .in_valid(in2_valid), .in_ready(in2_ready),
      .in_data(in2_data), .in_signed(1'b0),
      .out_valid(out2_valid), .out_ready(1'b1),
      .out_data(out2_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int c0, input int c1, input int c2, input int c3);
      for (int a = 0; a < 16; a++) begin
         cfg_we   = 1'b1;
         cfg_addr = 4'(a);
         cfg_data = 10'((a[0] ? c0 : 0) + (a[1] ? c1 : 0) +
                        (a[2] ? c2 : 0) + (a[3] ? c3 : 0));
         tick();
      end
      cfg_we = 1'b0;
   endtask

   task automatic start(input logic [31:0] d, input logic s);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = s;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic wait_done(input string tag, output logic [31:0] res,
                            output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({tag, "_seen"}, 32'(out_valid), 32'd1);
      res       = 32'(out_data);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [31:0] res;
   int          cyc;
   int          n;

   initial begin
      rst = 1'b1;
      cfg_we = 0; cfg_addr = 0; cfg_data = 0;
      in_valid = 0; in_data = 0; in_signed = 0; out_ready = 0;
      cfg2_we = 0; cfg2_addr = 0; cfg2_data = 0;
      in2_valid = 0; in2_data = 0;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      tick();

      prog(1, 2, 3, 4);
      start({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      wait_done("unsigned", res, cyc);
      chk("unsigned_latency", 32'(cyc), 32'd9);
      chk("unsigned_result", res, 32'd300);

      start({8'h04, 8'hFD, 8'h02, 8'hFF}, 1'b1);
      wait_done("signed", res, cyc);
      chk("signed_result", res, 32'd10);

      prog(255, 255, 255, 255);
      start(32'hFFFF_FFFF, 1'b0);
      wait_done("full", res, cyc);
      chk("full_scale", res, 32'd260100);

      prog(5, 0, 0, 0);
      start({8'd99, 8'd99, 8'd99, 8'd200}, 1'b0);
      wait_done("onehot", res, cyc);
      chk("onehot_result", res, 32'd1000);

      prog(1, 2, 3, 4);
      in_valid  = 1'b1;
      in_signed = 1'b0;
      in_data   = {8'd40, 8'd30, 8'd20, 8'd10};
      tick();
      in_data   = {8'd1, 8'd1, 8'd1, 8'd1};
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("bp_seen", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold_data", 32'(out_data), 32'd300);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_idle_valid", 32'(out_valid), 32'd0);
      chk("bp_idle_ready", 32'(in_ready), 32'd1);
      chk("bp_data_held", 32'(out_data), 32'd300);
      tick();
      chk("bp_second_acc", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      wait_done("second", res, cyc);
      chk("second_result", res, 32'd10);

      for (int a = 13; a < 16; a++) begin
         cfg2_we   = 1'b1;
         cfg2_addr = 4'(a);
         cfg2_data = 10'd1;
         tick();
      end
      cfg2_we = 1'b0;
      for (int v = 0; v < 16; v++) begin
         in2_valid = 1'b1;
         in2_data  = 4'(v);
         tick();
         in2_valid = 1'b0;
         n = 0;
         while (!out2_valid && n < 10) begin
            tick();
            n++;
         end
         chk($sformatf("thresh_v%0d", v), 32'(out2_data),
             (v >= 13) ? 32'd1 : 32'd0);
         tick();
      end

      prog(1, 2, 3, 4);
      start({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      start({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
      wait_done("readback", res, cyc);
      chk("readback_result", res, 32'd0);

      prog(1, 2, 3, 4);
      start({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
      tick();
      tick();
      tick();
      cfg_we   = 1'b1;
      cfg_addr = 4'd6;
      cfg_data = 10'd15;
      tick();
      cfg_we   = 1'b0;
      wait_done("live", res, cyc);
      chk("live_write_result", res, 32'd340);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
